data_ram_be: RTL and testbench

Parametrised byte-addressable data memory for the RISC-V core's load/store path, replacing the word-only RAM.
- Adds byte/half/word stores with byte enables, sign/zero-extended loads and misalignment detection.
- Read is registered (1-cycle latency), so the array maps to block RAM.
- Clearing is a sequential post-reset sweep instead of a one-cycle clear of every word.
- Sits between the core's load/store unit and the memory-stage register.

---
 rtl/ram_pkg.sv | 49 ++++
 rtl/ram_be_array.sv | 40 ++++
 rtl/data_ram_be.sv | 148 ++++++++++++++
 tb/tb_data_ram_be.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and helpers for the byte-enabled data RAM
//
// Purpose: access-size and FSM enums plus the byte-lane helpers used by
// data_ram_be. Helpers work on a 64-bit word / 3-bit offset so they serve
// both DATA_W=32 and DATA_W=64; callers truncate or zero-extend at the edges.
// Ports: none (package).
package ram_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

  typedef enum logic {INIT, READY} state_e;

  // Byte-enable mask covering bytes off .. off + 2**size - 1.
  function automatic logic [7:0] be_gen(size_e size, logic [2:0] off);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  // dword_ok is only set for a 64-bit word, which makes SZ_D illegal otherwise.
  function automatic logic is_aligned(size_e size, logic [2:0] off, logic dword_ok);
    case (size)
      SZ_B:    return 1'b1;
      SZ_H:    return (off[0] == 1'b0);
      SZ_W:    return (off[1:0] == 2'b00);
      default: return dword_ok && (off == 3'd0);
    endcase
  endfunction

  // Right-align the addressed bytes, then sign- or zero-extend to 64 bits.
  // Truncating the result to 32 bits keeps the extension correct.
  function automatic logic [63:0] load_ext(logic [63:0] word, logic [2:0] off,
                                           size_e size, logic uns);
    logic [63:0] s;
    s = word >> {off, 3'b000};
    case (size)
      SZ_B:    return uns ? {56'd0, s[7:0]}  : {{56{s[7]}},  s[7:0]};
      SZ_H:    return uns ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
      SZ_W:    return uns ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
      default: return s;
    endcase
  endfunction

endpackage

// File: rtl/ram_be_array.sv
// rtl/ram_be_array.sv - DEPTH x DATA_W storage with byte write enables
//
// Purpose: single-port array with per-byte write enable and a registered
// read port (read-first), no reset so it maps onto block RAM.
// Ports:
//   CLK      rising-edge clock
//   byte_en  per-byte write enable
//   addr     word address
//   wr_data  write data (already lane-aligned)
//   rd_en    capture mem[addr] into rd_data at the edge
//   rd_data  registered read data
module ram_be_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                CLK,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_en,
  output logic [DATA_W-1:0]   rd_data
);

  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  // Non-blocking read of the same word gives read-first behaviour.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < BE_W; i++) begin
      if (byte_en[i]) begin
        mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
    if (rd_en) begin
      rd_data <= mem[addr];
    end
  end

endmodule

// File: rtl/data_ram_be.sv
// rtl/data_ram_be.sv - byte-addressable data RAM for the load/store path
//
// Purpose: byte/half/word(/double) stores with byte enables, extended loads
// with 1-cycle latency, misalignment rejection and a post-reset clear sweep.
// Ports:
//   CLK, RESET_N   clock, asynchronous active-low reset
//   WRITE, READ    store / load request
//   SIZE           00 byte, 01 half, 10 word, 11 doubleword
//   UNSIGNED       1 zero-extend, 0 sign-extend loads
//   ADDRESS        byte address
//   DATA_IN        right-aligned store data
//   DATA_OUT       right-aligned, extended load result (holds between loads)
//   RD_VALID       pulse: DATA_OUT carries a new load result
//   MISALIGNED     pulse: previous request was rejected
//   BUSY           clear sweep in progress
module data_ram_be
  import ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    WRITE,
  input  logic                    READ,
  input  logic [1:0]              SIZE,
  input  logic                    UNSIGNED,
  input  logic [ADDR_W+OFF_W-1:0] ADDRESS,
  input  logic [DATA_W-1:0]       DATA_IN,
  output logic [DATA_W-1:0]       DATA_OUT,
  output logic                    RD_VALID,
  output logic                    MISALIGNED,
  output logic                    BUSY
);

  localparam int BE_W = DATA_W / 8;

  state_e              state, state_nxt;
  logic [ADDR_W-1:0]   cnt, cnt_nxt;
  logic [ADDR_W-1:0]   word_idx;
  logic [OFF_W-1:0]    off;
  size_e               size;
  logic                legal;

  logic [BE_W-1:0]     arr_be;
  logic [ADDR_W-1:0]   arr_addr;
  logic [DATA_W-1:0]   arr_wdata;
  logic                arr_rd;
  logic [DATA_W-1:0]   arr_rdata;

  logic                rd_accept, mis_nxt;
  logic                rd_valid_q, mis_q, uns_q;
  logic [OFF_W-1:0]    off_q;
  size_e               size_q;
  logic [DATA_W-1:0]   hold_q, load_res;

  assign word_idx = ADDRESS[ADDR_W+OFF_W-1:OFF_W];
  assign off      = ADDRESS[OFF_W-1:0];
  assign size     = size_e'(SIZE);
  assign legal    = is_aligned(size, 3'(off), DATA_W == 64);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    arr_addr  = word_idx;
    arr_be    = '0;
    arr_wdata = DATA_IN << {off, 3'b000};
    arr_rd    = 1'b0;
    rd_accept = 1'b0;
    mis_nxt   = 1'b0;
    case (state)
      INIT: begin
        // Requests are ignored; the array port belongs to the sweep.
        arr_addr  = cnt;
        arr_be    = '1;
        arr_wdata = '0;
        cnt_nxt   = cnt + 1'b1;   // wraps to 0 exactly as READY is entered
        if (&cnt) begin
          state_nxt = READY;
        end
      end
      READY: begin
        if (READ || WRITE) begin
          if (legal) begin
            if (WRITE) begin
              arr_be = BE_W'(be_gen(size, 3'(off)));
            end
            if (READ) begin
              arr_rd    = 1'b1;
              rd_accept = 1'b1;
            end
          end else begin
            mis_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= INIT;
      cnt        <= '0;
      rd_valid_q <= 1'b0;
      mis_q      <= 1'b0;
      off_q      <= '0;
      size_q     <= SZ_B;
      uns_q      <= 1'b0;
      hold_q     <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rd_valid_q <= rd_accept;
      mis_q      <= mis_nxt;
      if (rd_accept) begin
        off_q  <= off;
        size_q <= size;
        uns_q  <= UNSIGNED;
      end
      if (rd_valid_q) begin
        hold_q <= load_res;
      end
    end
  end

  // Extraction happens after the registered array read, so the result
  // appears combinationally in the RD_VALID cycle and is then held.
  assign load_res   = DATA_W'(load_ext(64'(arr_rdata), 3'(off_q), size_q, uns_q));
  assign DATA_OUT   = rd_valid_q ? load_res : hold_q;
  assign RD_VALID   = rd_valid_q;
  assign MISALIGNED = mis_q;
  assign BUSY       = (state == INIT);

  ram_be_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .CLK     (CLK),
    .byte_en (arr_be),
    .addr    (arr_addr),
    .wr_data (arr_wdata),
    .rd_en   (arr_rd),
    .rd_data (arr_rdata)
  );

endmodule

// File: tb/tb_data_ram_be.sv
// tb/tb_data_ram_be.sv - self-checking bench for data_ram_be
module tb_data_ram_be;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NBYTES = DEPTH * 4;

  logic        CLK;
  logic        RESET_N;
  logic        WRITE;
  logic        READ;
  logic [1:0]  SIZE;
  logic        UNSIGNED;
  logic [11:0] ADDRESS;
  logic [31:0] DATA_IN;
  logic [31:0] DATA_OUT;
  logic        RD_VALID;
  logic        MISALIGNED;
  logic        BUSY;

  int n_chk  = 0;
  int n_fail = 0;

  data_ram_be #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .WRITE      (WRITE),
    .READ       (READ),
    .SIZE       (SIZE),
    .UNSIGNED   (UNSIGNED),
    .ADDRESS    (ADDRESS),
    .DATA_IN    (DATA_IN),
    .DATA_OUT   (DATA_OUT),
    .RD_VALID   (RD_VALID),
    .MISALIGNED (MISALIGNED),
    .BUSY       (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Byte-level memory model: a request presented at an edge is answered
  // right after that edge.
  logic [7:0]  mdl [0:NBYTES-1];
  int          left = DEPTH;
  logic        e_rv = 1'b0, e_mis = 1'b0;
  logic [31:0] e_data = '0;

  always @(posedge CLK) begin
    if (!RESET_N) begin
      left = DEPTH; e_rv = 1'b0; e_mis = 1'b0; e_data = '0;
    end else if (left > 0) begin
      left--; e_rv = 1'b0; e_mis = 1'b0;
      if (left == 0) for (int i = 0; i < NBYTES; i++) mdl[i] = 8'h00;
    end else begin
      int nb; logic ok; logic [31:0] v;
      nb = 1 << SIZE;
      ok = (SIZE != 2'b11) && ((int'(ADDRESS) % nb) == 0);
      e_rv = 1'b0; e_mis = 1'b0;
      if ((READ || WRITE) && !ok) begin
        e_mis = 1'b1;
      end else begin
        if (READ) begin
          v = '0;
          for (int i = 0; i < nb; i++) v |= 32'(mdl[int'(ADDRESS) + i]) << (8 * i);
          if (!UNSIGNED && nb < 4 && v[8*nb-1]) v |= 32'hFFFF_FFFF << (8 * nb);
          e_data = v; e_rv = 1'b1;
        end
        if (WRITE) for (int i = 0; i < nb; i++) mdl[int'(ADDRESS) + i] = DATA_IN[8*i +: 8];
      end
    end
    #1;
    chk("mdl_busy", BUSY, left > 0);
    chk("mdl_rd_valid", RD_VALID, e_rv);
    chk("mdl_misaligned", MISALIGNED, e_mis);
    chk("mdl_data_out", DATA_OUT, e_data);
  end

  // Present one request for one edge; returns on the following negedge.
  task automatic op(input logic rd, input logic wr, input logic [1:0] sz,
                    input logic uns, input logic [11:0] a, input logic [31:0] d);
    READ = rd; WRITE = wr; SIZE = sz; UNSIGNED = uns; ADDRESS = a; DATA_IN = d;
    @(negedge CLK);
    READ = 1'b0; WRITE = 1'b0;
  endtask

  task automatic load(input string nm, input logic [1:0] sz, input logic uns,
                      input logic [11:0] a, input logic [31:0] exp);
    op(1'b1, 1'b0, sz, uns, a, 32'h0);
    chk({nm, "_valid"}, RD_VALID, 1'b1);
    chk(nm, DATA_OUT, exp);
  endtask

  task automatic store(input logic [1:0] sz, input logic [11:0] a, input logic [31:0] d);
    op(1'b0, 1'b1, sz, 1'b0, a, d);
  endtask

  task automatic bad(input string nm, input logic rd, input logic wr,
                     input logic [1:0] sz, input logic [11:0] a);
    op(rd, wr, sz, 1'b0, a, 32'hFFFF_FFFF);
    chk({nm, "_mis"}, MISALIGNED, 1'b1);
    chk({nm, "_rv"}, RD_VALID, 1'b0);
    @(negedge CLK);
    chk({nm, "_mis_drop"}, MISALIGNED, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    RESET_N = 1'b0; READ = 1'b0; WRITE = 1'b0; SIZE = 2'b00;
    UNSIGNED = 1'b0; ADDRESS = '0; DATA_IN = '0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", BUSY, 1'b1);
    chk("rst_data", DATA_OUT, 32'h0);
    chk("rst_rv", RD_VALID, 1'b0);
    chk("rst_mis", MISALIGNED, 1'b0);

    // 1: sweep length, cleared memory
    RESET_N = 1'b1;
    bc = 0;
    while (BUSY && bc < 2000) begin bc++; @(negedge CLK); end
    chk("sweep_len", bc, 1024);
    load("lw_000", 2'b10, 1'b0, 12'h000, 32'h0000_0000);
    load("lw_ffc", 2'b10, 1'b0, 12'hFFC, 32'h0000_0000);

    // 2: byte store and extended byte loads, back to back
    store(2'b00, 12'h003, 32'h0000_00AB);
    load("lw_after_sb", 2'b10, 1'b0, 12'h000, 32'hAB00_0000);
    load("lb_003", 2'b00, 1'b0, 12'h003, 32'hFFFF_FFAB);
    load("lbu_003", 2'b00, 1'b1, 12'h003, 32'h0000_00AB);

    // 3: half store over a word
    store(2'b10, 12'h010, 32'h1122_3344);
    store(2'b01, 12'h012, 32'h0000_BEEF);
    load("lw_010", 2'b10, 1'b0, 12'h010, 32'hBEEF_3344);
    load("lh_012", 2'b01, 1'b0, 12'h012, 32'hFFFF_BEEF);
    load("lhu_012", 2'b01, 1'b1, 12'h012, 32'h0000_BEEF);

    // 4: misaligned requests, including doubleword on a 32-bit RAM
    bad("sh_001", 1'b0, 1'b1, 2'b01, 12'h001);
    bad("lw_006", 1'b1, 1'b0, 2'b10, 12'h006);
    bad("sd_008", 1'b0, 1'b1, 2'b11, 12'h008);
    chk("hold_after_mis", DATA_OUT, 32'h0000_BEEF);
    load("lw_000_unch", 2'b10, 1'b0, 12'h000, 32'hAB00_0000);
    load("lw_004_unch", 2'b10, 1'b0, 12'h004, 32'h0000_0000);
    load("lw_008_unch", 2'b10, 1'b0, 12'h008, 32'h0000_0000);

    // 5: simultaneous read and write is read-first
    store(2'b10, 12'h020, 32'h0000_0005);
    op(1'b1, 1'b1, 2'b10, 1'b0, 12'h020, 32'h0000_0009);
    chk("rw_valid", RD_VALID, 1'b1);
    chk("rw_old", DATA_OUT, 32'h0000_0005);
    load("lw_020_new", 2'b10, 1'b0, 12'h020, 32'h0000_0009);
    store(2'b10, 12'h040, 32'h1234_5678);
    @(negedge CLK);
    chk("hold_idle", DATA_OUT, 32'h0000_0009);

    // 6: reset mid-sweep restarts it; writes during the sweep are dropped
    RESET_N = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (500) @(negedge CLK);
    chk("mid_busy", BUSY, 1'b1);
    RESET_N = 1'b0;
    @(negedge CLK);
    chk("mid_rst_busy", BUSY, 1'b1);
    chk("mid_rst_data", DATA_OUT, 32'h0);
    RESET_N = 1'b1;
    bc = 0;
    while (BUSY && bc < 2000) begin
      if (bc == 10) begin
        WRITE = 1'b1; SIZE = 2'b10; ADDRESS = 12'h040; DATA_IN = 32'hDEAD_BEEF;
      end else begin
        WRITE = 1'b0;
      end
      bc++;
      @(negedge CLK);
    end
    WRITE = 1'b0;
    chk("resweep_len", bc, 1024);
    load("lw_040_cleared", 2'b10, 1'b0, 12'h040, 32'h0000_0000);
    load("lw_020_cleared", 2'b10, 1'b0, 12'h020, 32'h0000_0000);
    repeat (2) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
